float2fxp_s_pipe: RTL and testbench

Streaming converter from IEEE-754 single precision to signed Q1.7 fixed point: the inverse of the existing signed fixed-point-to-FP32 converter. It sits at the output of the floating-point datapath and feeds quantized 8-bit activations and weights back into the fixed-point encoder/decoder arrays. It is a two-stage pipeline with a valid/ready handshake. It applies round-half-away-from-zero and saturation, and keeps a sticky saturation counter.

---
 rtl/float2fxp_s_pipe.sv | 151 +++++++++++++++
 tb/tb_float2fxp_s_pipe.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/float2fxp_s_pipe.sv
// Two-stage FP32 -> signed Q1.7 converter with valid/ready flow control.
// Rounds half away from zero, saturates, and counts saturated results.
module float2fxp_s_pipe #(
    parameter int WOI   = 1,
    parameter int WOF   = 7,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          fp32,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WOI+WOF-1:0]   fxp,
    output logic                 out_sat,
    output logic [CNT_W-1:0]     sat_cnt,
    input  logic                 cnt_clr
);

    localparam int W = WOI + WOF;
    localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MAX_NEG = {1'b1, {(W-1){1'b0}}};

    localparam logic [1:0] CLS_ZERO = 2'd0;
    localparam logic [1:0] CLS_NAN  = 2'd1;
    localparam logic [1:0] CLS_INF  = 2'd2;
    localparam logic [1:0] CLS_NORM = 2'd3;

    logic en;
    assign en       = ~(out_valid & ~out_ready);
    assign in_ready = en;

    logic              d_s;
    logic signed [9:0] d_k;
    logic [23:0]       d_sig;
    logic [1:0]        d_cls;

    always_comb begin
        d_s   = fp32[31];
        d_k   = $signed({2'b00, fp32[30:23]}) - 10'sd120;
        d_sig = {1'b1, fp32[22:0]};
        if (fp32[30:23] == 8'd0)
            d_cls = CLS_ZERO;
        else if (fp32[30:23] == 8'hFF)
            d_cls = (fp32[22:0] != 23'd0) ? CLS_NAN : CLS_INF;
        else
            d_cls = CLS_NORM;
    end

    logic              s1_valid;
    logic              s1_s;
    logic signed [9:0] s1_k;
    logic [23:0]       s1_sig;
    logic [1:0]        s1_cls;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_s     <= 1'b0;
            s1_k     <= '0;
            s1_sig   <= '0;
            s1_cls   <= CLS_ZERO;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_s     <= d_s;
            s1_k     <= d_k;
            s1_sig   <= d_sig;
            s1_cls   <= d_cls;
        end
    end

    // Bit 0 of sel is the first discarded bit, bits 8:1 the integer part (k in -1..7).
    logic        big;
    logic        tiny;
    logic [4:0]  sh;
    logic [8:0]  sel;
    logic [9:0]  mag;
    logic [W-1:0] r_fxp;
    logic        r_sat;

    always_comb begin
        big  = (s1_k >= 10'sd8);
        tiny = (s1_k <= -10'sd2);
        sh   = 5'd16;
        if (!big && !tiny)
            sh = 5'(10'sd23 - s1_k);
        sel = 9'({s1_sig, 1'b0} >> sh);
        mag = tiny ? 10'd0 : ({2'b00, sel[8:1]} + {9'd0, sel[0]});

        r_fxp = '0;
        r_sat = 1'b0;
        case (s1_cls)
            CLS_ZERO: begin
                r_fxp = '0;
                r_sat = 1'b0;
            end
            CLS_NAN: begin
                r_fxp = '0;
                r_sat = 1'b1;
            end
            CLS_INF: begin
                r_fxp = s1_s ? MAX_NEG : MAX_POS;
                r_sat = 1'b1;
            end
            default: begin
                if (!s1_s) begin
                    if (big || mag > 10'd127) begin
                        r_fxp = MAX_POS;
                        r_sat = 1'b1;
                    end else begin
                        r_fxp = mag[W-1:0];
                    end
                end else begin
                    if (big || mag > 10'd128) begin
                        r_fxp = MAX_NEG;
                        r_sat = 1'b1;
                    end else begin
                        r_fxp = -mag[W-1:0];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            fxp       <= '0;
            out_sat   <= 1'b0;
        end else if (en) begin
            out_valid <= s1_valid;
            fxp       <= r_fxp;
            out_sat   <= r_sat;
        end
    end

    // A clear coinciding with a counted transfer leaves that transfer counted.
    logic inc;
    assign inc = out_valid & out_ready & out_sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sat_cnt <= '0;
        else if (cnt_clr)
            sat_cnt <= inc ? CNT_W'(1) : '0;
        else if (inc && (sat_cnt != {CNT_W{1'b1}}))
            sat_cnt <= sat_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_float2fxp_s_pipe.sv
// Scoreboard bench for float2fxp_s_pipe: real-arithmetic reference model,
// randomized and directed words, backpressure, counter and reset checks.
module tb_float2fxp_s_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] fp32 = '0;
    logic        out_ready = 1'b1;
    logic        cnt_clr = 1'b0;

    logic        in_ready, out_valid, out_sat;
    logic [7:0]  fxp;
    logic [15:0] sat_cnt;
    logic        in_ready2, out_valid2, out_sat2;
    logic [7:0]  fxp2;
    logic [1:0]  sat_cnt2;

    float2fxp_s_pipe #(.WOI(1), .WOF(7), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .fp32(fp32), .out_valid(out_valid), .out_ready(out_ready), .fxp(fxp),
        .out_sat(out_sat), .sat_cnt(sat_cnt), .cnt_clr(cnt_clr)
    );

    float2fxp_s_pipe #(.WOI(1), .WOF(7), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .fp32(fp32), .out_valid(out_valid2), .out_ready(out_ready), .fxp(fxp2),
        .out_sat(out_sat2), .sat_cnt(sat_cnt2), .cnt_clr(cnt_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] f;
        logic       s;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;
    int   exp_cnt = 0;
    int   exp_cnt2 = 0;
    bit   lat_chk = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    endfunction

    // Reference: value * 128 in real arithmetic, rounded half away from zero, then clamped.
    function automatic void model(input logic [31:0] w, output logic [7:0] f, output logic s);
        int  e;
        int  mag;
        real r;
        e = int'(w[30:23]);
        f = 8'h00;
        s = 1'b0;
        if (e == 255) begin
            s = 1'b1;
            if (w[22:0] != 23'd0) f = 8'h00;
            else f = w[31] ? 8'h80 : 8'h7F;
        end else if (e != 0) begin
            if (e >= 136) mag = 1000;
            else begin
                r = real'(int'(w[22:0]) + 8388608);
                for (int i = 0; i < 143 - e; i++) r = r / 2.0;
                mag = $rtoi(r + 0.5);
            end
            if (!w[31]) begin
                if (mag > 127) begin f = 8'h7F; s = 1'b1; end
                else f = 8'(mag);
            end else begin
                if (mag > 128) begin f = 8'h80; s = 1'b1; end
                else f = 8'((256 - mag) % 256);
            end
        end
    endfunction

    logic       prev_stall = 1'b0;
    logic [7:0] prev_f;
    logic       prev_s;

    always @(negedge clk) begin
        exp_t e;
        logic ev;
        logic [7:0] mf;
        logic ms;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            check("sat_cnt", 32'(sat_cnt), 32'(exp_cnt));
            check("sat_cnt_w2", 32'(sat_cnt2), 32'(exp_cnt2));
            check("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
            check("in_ready_w2", 32'(in_ready2), 32'(!(out_valid && !out_ready)));
            if (prev_stall) begin
                check("stall_valid", 32'(out_valid), 32'(1));
                check("stall_fxp", 32'(fxp), 32'(prev_f));
                check("stall_sat", 32'(out_sat), 32'(prev_s));
            end
            ev = 1'b0;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL unexpected_out: got fxp %0h with no pending word, expected none", fxp);
                end else begin
                    e = q.pop_front();
                    check("fxp", 32'(fxp), 32'(e.f));
                    check("out_sat", 32'(out_sat), 32'(e.s));
                    check("out_valid_w2", 32'(out_valid2), 32'(1));
                    check("fxp_w2", 32'(fxp2), 32'(e.f));
                    if (lat_chk) check("latency", 32'(cyc - e.cyc), 32'(2));
                    ev = e.s;
                end
            end
            if (cnt_clr) begin
                exp_cnt = ev ? 1 : 0;
                exp_cnt2 = ev ? 1 : 0;
            end else if (ev) begin
                if (exp_cnt < 65535) exp_cnt++;
                if (exp_cnt2 < 3) exp_cnt2++;
            end
            prev_stall = out_valid && !out_ready;
            prev_f = fxp;
            prev_s = out_sat;
            if (in_valid && in_ready) begin
                model(fp32, mf, ms);
                e.f = mf;
                e.s = ms;
                e.cyc = cyc;
                q.push_back(e);
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] w);
        int n = 0;
        in_valid = 1'b1;
        fp32 = w;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 100);
        if (!in_ready) begin
            checks++;
            $display("[TB] FAIL accept_timeout: in_ready stayed 0, expected 1 within 100 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            $display("[TB] FAIL drain_timeout: %0d results pending, expected 0", q.size());
        end
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] randWord();
        logic [7:0] e;
        int pick;
        pick = $urandom_range(0, 19);
        if (pick == 0) e = 8'h00;
        else if (pick == 1) e = 8'hFF;
        else e = 8'($urandom_range(100, 140));
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    logic [31:0] basic[14] = '{32'h3F000000, 32'hBF800000, 32'h3C000000, 32'h00000000,
                               32'h3B800000, 32'h3B000000, 32'hBF7F0000, 32'h3F7F0000,
                               32'h3F800000, 32'hC2C80000, 32'h7FC00000, 32'hFF800000,
                               32'h00400000, 32'h80000000};

    initial begin
        #12;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_fxp", 32'(fxp), 32'(0));
        check("rst_out_sat", 32'(out_sat), 32'(0));
        check("rst_sat_cnt", 32'(sat_cnt), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'(1));

        foreach (basic[i]) applyStimulus(basic[i]);
        idle();
        waitDrain();

        for (int i = 0; i < 150; i++) begin
            applyStimulus(randWord());
            if ($urandom_range(0, 7) == 0) begin
                idle();
                @(posedge clk);
                #1;
            end
        end
        idle();
        waitDrain();

        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        repeat (3) applyStimulus(32'h3F800000);
        idle();
        waitDrain();
        check("cnt_three", 32'(sat_cnt), 32'(3));
        repeat (2) applyStimulus(32'hC2C80000);
        idle();
        waitDrain();
        check("cnt_five", 32'(sat_cnt), 32'(5));
        check("cnt_w2_held", 32'(sat_cnt2), 32'(3));

        begin
            bit hit = 1'b0;
            repeat (3) applyStimulus(32'h7FC00000);
            idle();
            for (int i = 0; i < 10 && !hit; i++) begin
                if (out_valid && out_ready && out_sat) begin
                    cnt_clr = 1'b1;
                    hit = 1'b1;
                end
                @(posedge clk);
                #1;
                cnt_clr = 1'b0;
            end
            checks++;
            if (hit) passed++;
            else $display("[TB] FAIL clr_align: saw no saturating output, expected one");
            waitDrain();
        end

        lat_chk = 1'b0;
        begin
            bit done = 1'b0;
            logic [3:0] pat = 4'b1001;
            fork
                begin
                    for (int i = 0; i < 8; i++) applyStimulus(randWord());
                    idle();
                    done = 1'b1;
                end
                begin
                    int k = 0;
                    while (!done) begin
                        out_ready = pat[k % 4];
                        k++;
                        @(posedge clk);
                        #1;
                    end
                end
            join
            out_ready = 1'b1;
            waitDrain();
        end
        lat_chk = 1'b1;

        applyStimulus(32'h3F000000);
        applyStimulus(32'h3F800000);
        idle();
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'(0));
        check("midrst_sat_cnt", 32'(sat_cnt), 32'(0));
        check("midrst_fxp", 32'(fxp), 32'(0));
        q.delete();
        exp_cnt = 0;
        exp_cnt2 = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        applyStimulus(32'hBF800000);
        idle();
        waitDrain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
